// File: rtl/serial_paralelo_rx_if.sv
// rtl/serial_paralelo_rx_if.sv - serial line in and recovered byte stream out
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output data_in,
    input  data_out, valid_out, byte_strobe, active
  );

  modport slave (
    input  data_in,
    output data_out, valid_out, byte_strobe, active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// rtl/serial_paralelo_rx.sv - 1:8 deserializer with comma alignment and lock
module serial_paralelo_rx #(
  parameter int         BC_NEEDED = 4,
  parameter logic [7:0] COMMA     = 8'hBC
) (
  input  logic                  clk_8f,
  input  logic                  reset,
  serial_paralelo_rx_if.slave   bus
);

  typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} state_t;

  localparam logic [3:0] BC_N = 4'(BC_NEEDED);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_shreg;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0] r_bc_cnt, w_bc_cnt_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_strobe, w_strobe_nxt;

  logic [7:0] w_cand;
  logic       w_is_comma;
  logic       w_boundary;
  logic [3:0] w_bc_inc;

  assign w_cand     = {r_shreg[6:0], bus.data_in};
  assign w_is_comma = (w_cand == COMMA);
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_bc_inc   = r_bc_cnt + 4'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    w_bc_cnt_nxt  = r_bc_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_strobe_nxt  = 1'b0;
    case (r_state)
      SEARCH: begin
        // Bit-sliding search: every edge is a potential byte boundary.
        w_bit_cnt_nxt = 3'd0;
        if (w_is_comma) begin
          w_bc_cnt_nxt = 4'd1;
          w_state_nxt  = (BC_N == 4'd1) ? ACTIVE : SYNC;
        end
      end
      SYNC: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            if (w_bc_inc >= BC_N) begin
              w_bc_cnt_nxt = BC_N;
              w_state_nxt  = ACTIVE;
            end else begin
              w_bc_cnt_nxt = w_bc_inc;
            end
          end else begin
            w_bc_cnt_nxt = 4'd0;
            w_state_nxt  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (w_boundary) begin
          w_strobe_nxt = 1'b1;
          if (w_is_comma) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_data_nxt  = w_cand;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_shreg   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_bc_cnt  <= 4'd0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_cand;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bc_cnt  <= w_bc_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_strobe  <= w_strobe_nxt;
    end
  end

  assign bus.data_out    = r_data;
  assign bus.valid_out   = r_valid;
  assign bus.byte_strobe = r_strobe;
  assign bus.active      = (r_state == ACTIVE);

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb/tb_serial_paralelo_rx.sv - bench for serial_paralelo_rx (BC_NEEDED 4 and 1)
module tb_serial_paralelo_rx;

  logic clk_8f = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_8f = ~clk_8f;

  serial_paralelo_rx_if bus4 ();
  serial_paralelo_rx_if bus1 ();

  serial_paralelo_rx #(.BC_NEEDED(4), .COMMA(8'hBC)) u_dut4 (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus4.slave)
  );

  serial_paralelo_rx #(.BC_NEEDED(1), .COMMA(8'hBC)) u_dut1 (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits since reset kept in a queue; byte boundaries are
  // positions a multiple of 8 bits after the comma that started alignment.
  localparam int M_SEARCH = 0, M_SYNC = 1, M_ACTIVE = 2;
  bit   hist[$];
  int   need[2] = '{4, 1};
  int   m_mode[2], m_cnt[2], m_anchor[2];
  logic [7:0] m_data[2];
  logic m_valid[2], m_strobe[2];

  function automatic logic [7:0] last_byte();
    logic [7:0] r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      int idx = hist.size() - 8 + k;
      if (idx >= 0) r[7-k] = hist[idx];
    end
    return r;
  endfunction

  task automatic model_step(input bit b, input bit rst);
    logic [7:0] v;
    int n;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = M_SEARCH; m_cnt[i] = 0; m_anchor[i] = 0;
        m_data[i] = 8'h00; m_valid[i] = 1'b0; m_strobe[i] = 1'b0;
      end
      return;
    end
    hist.push_back(b);
    v = last_byte();
    n = hist.size();
    for (int i = 0; i < 2; i++) begin
      m_strobe[i] = 1'b0;
      if (m_mode[i] == M_SEARCH) begin
        if (v == 8'hBC) begin
          m_anchor[i] = n;
          m_cnt[i]    = 1;
          m_mode[i]   = (need[i] <= 1) ? M_ACTIVE : M_SYNC;
        end
      end else if ((n - m_anchor[i]) % 8 == 0) begin
        if (m_mode[i] == M_SYNC) begin
          if (v == 8'hBC) begin
            m_cnt[i]++;
            if (m_cnt[i] >= need[i]) m_mode[i] = M_ACTIVE;
          end else begin
            m_cnt[i]  = 0;
            m_mode[i] = M_SEARCH;
          end
        end else begin
          m_strobe[i] = 1'b1;
          if (v == 8'hBC) m_valid[i] = 1'b0;
          else begin m_data[i] = v; m_valid[i] = 1'b1; end
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("m4.data_out",    bus4.data_out,    m_data[0]);
    chk("m4.valid_out",   8'(bus4.valid_out),   8'(m_valid[0]));
    chk("m4.byte_strobe", 8'(bus4.byte_strobe), 8'(m_strobe[0]));
    chk("m4.active",      8'(bus4.active),      8'(m_mode[0] == M_ACTIVE));
    chk("m1.data_out",    bus1.data_out,    m_data[1]);
    chk("m1.valid_out",   8'(bus1.valid_out),   8'(m_valid[1]));
    chk("m1.byte_strobe", 8'(bus1.byte_strobe), 8'(m_strobe[1]));
    chk("m1.active",      8'(bus1.active),      8'(m_mode[1] == M_ACTIVE));
  endtask

  task automatic send_bit(input bit b, input bit rst);
    @(negedge clk_8f);
    bus4.data_in = b;
    bus1.data_in = b;
    reset        = rst;
    @(posedge clk_8f);
    #1;
    model_step(b, rst);
    compare_model();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       e_active;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_strobe;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] rb;
    logic [7:0] b33;
    tbl[0] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{8'hBC, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1};
    tbl[6] = '{8'hBC, 1'b1, 1'b0, 8'h3C, 1'b1};
    tbl[7] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1};

    bus4.data_in = 1'b0;
    bus1.data_in = 1'b0;

    // Reset state
    send_bit(1'b1, 1'b1);
    chk("rst.data_out",  bus4.data_out, 8'h00);
    chk("rst.valid_out", 8'(bus4.valid_out), 8'h00);
    chk("rst.strobe",    8'(bus4.byte_strobe), 8'h00);
    chk("rst.active",    8'(bus4.active), 8'h00);

    // Aligned lock, data, comma gap in ACTIVE
    for (int i = 0; i < 8; i++) begin
      send_byte(tbl[i].tx);
      chk($sformatf("tbl%0d.active", i), 8'(bus4.active), 8'(tbl[i].e_active));
      chk($sformatf("tbl%0d.valid", i),  8'(bus4.valid_out), 8'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.data", i),   bus4.data_out, tbl[i].e_data);
      chk($sformatf("tbl%0d.strobe", i), 8'(bus4.byte_strobe), 8'(tbl[i].e_strobe));
    end

    // Misaligned start with 3'b101 garbage
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    repeat (3) send_byte(8'hBC);
    chk("mis.active3", 8'(bus4.active), 8'h00);
    send_byte(8'hBC);
    chk("mis.active4", 8'(bus4.active), 8'h01);
    send_byte(8'h5A);
    chk("mis.data5A", bus4.data_out, 8'h5A);
    chk("mis.valid5A", 8'(bus4.valid_out), 8'h01);
    send_byte(8'hFF);
    chk("mis.dataFF", bus4.data_out, 8'hFF);

    // SYNC broken by a non-comma, then re-lock
    send_bit(1'b0, 1'b1);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
    chk("sync.fail_active", 8'(bus4.active), 8'h00);
    repeat (3) send_byte(8'hBC);
    chk("sync.relock3", 8'(bus4.active), 8'h00);
    send_byte(8'hBC);
    chk("sync.relock4", 8'(bus4.active), 8'h01);
    send_byte(8'h42);
    chk("sync.data42", bus4.data_out, 8'h42);

    // Reset mid-byte in ACTIVE, then re-acquire
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("mid.data",   bus4.data_out, 8'h00);
    chk("mid.valid",  8'(bus4.valid_out), 8'h00);
    chk("mid.active", 8'(bus4.active), 8'h00);
    chk("mid.active1", 8'(bus1.active), 8'h00);
    repeat (3) send_byte(8'hBC);
    chk("mid.reacq3", 8'(bus4.active), 8'h00);
    send_byte(8'hBC);
    chk("mid.reacq4", 8'(bus4.active), 8'h01);

    // Reset on the boundary edge: no strobe
    b33 = 8'h33;
    for (int i = 7; i >= 1; i--) send_bit(b33[i], 1'b0);
    send_bit(b33[0], 1'b1);
    chk("bnd.strobe", 8'(bus4.byte_strobe), 8'h00);
    chk("bnd.valid",  8'(bus4.valid_out), 8'h00);
    chk("bnd.active", 8'(bus4.active), 8'h00);

    // BC_NEEDED=1 instance locks on a single comma
    send_byte(8'hBC);
    chk("one.active1", 8'(bus1.active), 8'h01);
    chk("one.active4", 8'(bus4.active), 8'h00);
    send_byte(8'h81);
    chk("one.data81",  bus1.data_out, 8'h81);
    chk("one.valid81", 8'(bus1.valid_out), 8'h01);
    chk("one.strobe",  8'(bus1.byte_strobe), 8'h01);

    // Randomized segments against the model
    for (int seg = 0; seg < 24; seg++) begin
      send_bit(1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom));
      repeat ($urandom_range(1, 6)) send_byte(8'hBC);
      for (int k = 0; k < 12; k++) begin
        rb = ($urandom_range(0, 4) == 0) ? 8'hBC : 8'($urandom);
        send_byte(rb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Receive-side partner of the 8:1 parallel-to-serial transmitter; sits directly downstream of the serial line.
- Shifts in one bit per clk_8f edge, MSB first, and finds byte alignment from the idle comma 8'hBC.
- After a run of aligned commas it declares the link active and presents recovered bytes as data_out with valid_out.
- Comma bytes are never forwarded; they mean the transmitter had no valid data.

Parameters:
BC_NEEDED, 4, number of consecutive byte-aligned 8'hBC required to enter ACTIVE (legal 1..15).
COMMA, 8'hBC, idle/alignment symbol.

Ports:
clk_8f  input  1  bit clock, one serial bit per rising edge; the only clock.
reset  input  1  synchronous, active-high; sampled on rising clk_8f.
data_in  input  1  serial bit stream, MSB of each byte first.
data_out  output  8  last recovered non-comma byte.
valid_out  output  1  data_out holds a byte received in the current byte period.
byte_strobe  output  1  one-cycle pulse at every byte boundary while ACTIVE.
active  output  1  link aligned and locked (state == ACTIVE).

Behaviour:
- Reset (reset=1 at an edge):
  - shreg=0, bit_cnt=0, bc_cnt=0, state=SEARCH.
  - data_out=8'h00, valid_out=0, byte_strobe=0, active=0.
  - Reset overrides all other activity, including mid-byte and in ACTIVE.
- Candidate byte: cand = {shreg[6:0], data_in}, combinational.
- Every non-reset edge: shreg <= cand.
- Byte boundary: in SYNC/ACTIVE, the edge where bit_cnt==7.
  - bit_cnt increments mod 8 each edge; 7 wraps to 0.
- SEARCH:
  - Check cand every edge, i.e. bit-sliding search.
  - cand==COMMA -> bit_cnt<=0, bc_cnt<=1. If BC_NEEDED==1 go to ACTIVE, else go to SYNC.
  - Otherwise stay in SEARCH; bit_cnt is don't-care, held at 0.
- SYNC, evaluated at byte boundaries only:
  - cand==COMMA -> bc_cnt+1. When that value reaches BC_NEEDED, go to ACTIVE.
  - cand!=COMMA -> bc_cnt<=0, go to SEARCH; the search resumes on the next edge.
- ACTIVE, at each byte boundary:
  - byte_strobe=1 for that cycle.
  - cand!=COMMA -> data_out<=cand, valid_out<=1.
  - cand==COMMA -> valid_out<=0, data_out holds.
- Between boundaries: byte_strobe=0; data_out and valid_out hold for the full 8-bit period.
- ACTIVE is left only by reset; there is no loss-of-sync detection in this block.
- active is 1 exactly when state==ACTIVE and is registered; it rises on the edge that completes the BC_NEEDED-th comma.
- Latency: data_out, valid_out and byte_strobe update on the same edge that samples a byte's last bit (LSB). They are visible one edge after the transmitter drives that LSB.
- Simultaneous events: a boundary on the same edge as reset -> reset wins and no strobe is produced.
- Width rules:
  - bc_cnt is 4 bits and saturates at BC_NEEDED.
  - bit_cnt is 3 bits and wraps naturally.

Test Plan:
1. Reset, then a byte-aligned stream of 4x 8'hBC followed by 8'hA5, 8'h3C -> active rises on the LSB edge of the 4th BC. valid_out=1 with data_out=8'hA5, then 8'h3C, each held 8 cycles. byte_strobe pulses every 8 cycles.
2. 3 garbage bits 3'b101 before the BC stream (misaligned) -> alignment locks on the first full BC. The following bytes 8'h5A, 8'hFF are recovered correctly.
3. In ACTIVE, send 8'hBC between data bytes -> valid_out=0 for that byte period; data_out keeps the previous byte; active stays 1.
4. SYNC interrupted: BC, BC, 8'h00 -> return to SEARCH with active=0. A subsequent 4xBC locks normally.
5. Assert reset for one edge mid-byte in ACTIVE -> all outputs zero on the next edge. The block re-acquires only after a fresh 4xBC.
6. BC_NEEDED=1 build: a single aligned BC -> active=1 on its LSB edge. The next byte 8'h81 is output with valid_out=1.
